// File: rtl/unpack_arbiter_pkg.sv
// rtl/unpack_arbiter_pkg.sv - shared types and round-robin search for unpack_arbiter
package unpack_arbiter_pkg;

  localparam int max_req_c   = 32;
  localparam int max_req_w_c = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Lowest offset from start (with wrap) whose request bit is set; returns start when none.
  function automatic int rr_pick(input logic [max_req_c-1:0] req, input int start, input int n);
    int idx;
    int pick;
    pick = start;
    for (int off = n - 1; off >= 0; off--) begin
      idx = start + off;
      if (idx >= n) idx = idx - n;
      if (req[idx[max_req_w_c-1:0]]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/counter_roll.sv
// rtl/counter_roll.sv - up counter that rolls over to zero after max_p
module counter_roll #(
  parameter int width_p = 4,
  parameter int max_p   = 15
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               clear_i,
  input  logic               incr_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_p);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i) begin
      count_d = (count_q == max_lp) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) count_q <= '0;
    else           count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/unpack_arbiter.sv
// rtl/unpack_arbiter.sv - round-robin burst arbiter sharing one unpacker between requesters
// Optional stalled-grant release: define UNPACK_ARBITER_TIMEOUT_EN.
module unpack_arbiter
  import unpack_arbiter_pkg::*;
#(
  parameter int num_req_p      = 4,
  parameter int packed_width_p = 8,
  parameter int burst_len_p    = 16,
  parameter int timeout_p      = 8
) (
  input  logic                                clk_i,
  input  logic                                reset_ni,
  input  logic [num_req_p*packed_width_p-1:0] packed_i,
  input  logic [num_req_p-1:0]                valid_i,
  output logic [num_req_p-1:0]                ready_o,
  output logic [packed_width_p-1:0]           packed_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [$clog2(num_req_p)-1:0]        chan_o,
  output logic                                last_o
);

  localparam int chan_w_lp = $clog2(num_req_p);
  localparam int cnt_w_lp  = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam logic [cnt_w_lp-1:0]  last_cnt_lp  = cnt_w_lp'(burst_len_p - 1);
  localparam logic [chan_w_lp-1:0] last_chan_lp = chan_w_lp'(num_req_p - 1);

  if (num_req_p < 2 || num_req_p > max_req_c || burst_len_p < 1 || timeout_p < 1) begin : g_bad_params
    $error("unpack_arbiter: illegal parameter value");
  end

  state_e                 state_q, state_d;
  logic [chan_w_lp-1:0]   grant_q, grant_d;
  logic [chan_w_lp-1:0]   rr_ptr_q, rr_ptr_d;
  logic [chan_w_lp-1:0]   pick, next_ptr;
  logic [max_req_c-1:0]   req_ext;
  logic [cnt_w_lp-1:0]    count;
  logic [packed_width_p-1:0] words [num_req_p];
  logic                   sel_valid, fire, at_last, burst_done, timeout_hit;

  for (genvar g = 0; g < num_req_p; g++) begin : g_words
    assign words[g] = packed_i[g*packed_width_p +: packed_width_p];
  end

  assign req_ext    = max_req_c'(valid_i);
  assign pick       = chan_w_lp'(rr_pick(req_ext, int'(rr_ptr_q), num_req_p));
  assign next_ptr   = (grant_q == last_chan_lp) ? '0 : grant_q + 1'b1;
  assign sel_valid  = valid_i[grant_q];
  assign fire       = (state_q == BUSY) && sel_valid && ready_i;
  assign at_last    = (state_q == BUSY) && (count == last_cnt_lp);
  assign burst_done = fire && at_last;

`ifdef UNPACK_ARBITER_TIMEOUT_EN
  localparam int to_w_lp = $clog2(timeout_p + 1);
  logic [to_w_lp-1:0] to_q, to_d;

  assign to_d        = (state_q == BUSY && !sel_valid) ? to_q + 1'b1 : '0;
  assign timeout_hit = (state_q == BUSY) && !sel_valid && (to_q == to_w_lp'(timeout_p - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_ni) to_q <= '0;
    else           to_q <= to_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Counter wraps on its own at burst end; clear is only needed for a timed-out grant.
  counter_roll #(
    .width_p (cnt_w_lp),
    .max_p   (burst_len_p - 1)
  ) u_beat_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (timeout_hit),
    .incr_i   (fire),
    .count_o  (count)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|valid_i) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (burst_done || timeout_hit) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
    endcase
  end

  // Pass-through is purely combinational so the granted stream sees no added latency.
  always_comb begin
    packed_o = '0;
    valid_o  = 1'b0;
    ready_o  = '0;
    last_o   = 1'b0;
    if (state_q == BUSY) begin
      packed_o         = words[grant_q];
      valid_o          = sel_valid;
      ready_o[grant_q] = ready_i;
      last_o           = at_last;
    end
  end

  assign chan_o = grant_q;

endmodule

// File: tb/tb_unpack_arbiter.sv
// tb/tb_unpack_arbiter.sv - scoreboard bench for unpack_arbiter (4 requesters, burst of 4)
module tb_unpack_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int BL = 4;
  localparam int TO = 8;

  typedef struct packed {
    logic [1:0]   chan;
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            reset_ni;
  logic [NR*W-1:0] packed_i;
  logic [NR-1:0]   valid_i;
  logic [NR-1:0]   ready_o;
  logic [W-1:0]    packed_o;
  logic            valid_o;
  logic            ready_i;
  logic [1:0]      chan_o;
  logic            last_o;

  int   errors = 0;
  int   checks = 0;
  int   seq[NR];
  int   exp_seq[NR];
  exp_t q[$];

  always #5 clk_i = ~clk_i;

  unpack_arbiter #(
    .num_req_p      (NR),
    .packed_width_p (W),
    .burst_len_p    (BL),
    .timeout_p      (TO)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .packed_i (packed_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .packed_o (packed_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .chan_o   (chan_o),
    .last_o   (last_o)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int k, input int s);
    return W'((k * 64) + (s % 64));
  endfunction

  task automatic drive_words();
    for (int k = 0; k < NR; k++) packed_i[k*W +: W] = word_of(k, seq[k]);
  endtask

  task automatic push_burst(input int k, input int n, input bit with_last);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.chan = 2'(k);
      e.data = word_of(k, exp_seq[k]);
      e.last = with_last && (i == n - 1);
      q.push_back(e);
      exp_seq[k]++;
    end
  endtask

  // One cycle: compare at negedge against the scoreboard head, then let requesters advance.
  task automatic tick(output logic vo);
    logic [NR-1:0] fired;
    logic [NR-1:0] exp_rdy;
    exp_t          e;
    @(negedge clk_i);
    vo    = valid_o;
    fired = valid_i & ready_o;
    if (valid_o) begin
      if (q.size() == 0) begin
        check_val("unexpected_word", 32'(valid_o), 32'd0);
      end else begin
        e       = q[0];
        exp_rdy = ready_i ? (NR'(1) << e.chan) : '0;
        check_val("chan", 32'(chan_o), 32'(e.chan));
        check_val("data", 32'(packed_o), 32'(e.data));
        check_val("ready_o", 32'(ready_o), 32'(exp_rdy));
        if (ready_i) begin
          check_val("last", 32'(last_o), 32'(e.last));
          void'(q.pop_front());
        end
      end
    end
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NR; k++) if (fired[k]) seq[k]++;
    drive_words();
  endtask

  task automatic drain(input string tag, input int budget);
    logic vo;
    int   n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick(vo);
      n++;
    end
    check_val(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    reset_ni = 1'b0;
    ready_i  = 1'b1;
    @(posedge clk_i);
    #1;
    check_val({tag, "_valid_o"}, 32'(valid_o), 32'd0);
    check_val({tag, "_ready_o"}, 32'(ready_o), 32'd0);
    check_val({tag, "_last_o"}, 32'(last_o), 32'd0);
    check_val({tag, "_chan_o"}, 32'(chan_o), 32'd0);
    check_val({tag, "_packed_o"}, 32'(packed_o), 32'd0);
    reset_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic vo;
    bit   pat[4];
    int   t;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < NR; k++) begin
      seq[k]     = 0;
      exp_seq[k] = 0;
    end
    drive_words();
    valid_i = '1;
    apply_reset("reset");

    // Single requester: bubble, 4 words, bubble, re-grant of the same channel.
    valid_i = 4'b0100;
    ready_i = 1'b1;
    push_burst(2, BL, 1'b1);
    push_burst(2, BL, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(vo);
      check_val("single_bubble", 32'(vo), 32'(i % 5 != 0));
    end
    check_val("single_drain", 32'(q.size()), 32'd0);
    valid_i = '0;

    // All requesting: strict 0,1,2,3,0 order, one full burst each.
    apply_reset("reset2");
    valid_i = 4'b1111;
    push_burst(0, BL, 1'b1);
    push_burst(1, BL, 1'b1);
    push_burst(2, BL, 1'b1);
    push_burst(3, BL, 1'b1);
    push_burst(0, BL, 1'b1);
    drain("all_drain", 60);
    valid_i = '0;

    // Backpressure on channel 1.
    apply_reset("reset3");
    valid_i = 4'b0010;
    push_burst(1, BL, 1'b1);
    t = 0;
    while (q.size() != 0 && t < 40) begin
      ready_i = pat[t % 4];
      tick(vo);
      t++;
    end
    check_val("bp_drain", 32'(q.size()), 32'd0);
    ready_i = 1'b1;
    valid_i = '0;

    // Reset after 2 of 4 words, then fresh arbitration from pointer 0.
    apply_reset("reset4");
    valid_i = 4'b1000;
    push_burst(3, 2, 1'b0);
    for (int i = 0; i < 3; i++) tick(vo);
    check_val("mid_pre_drain", 32'(q.size()), 32'd0);
    apply_reset("mid_reset");
    valid_i = 4'b1010;
    push_burst(1, BL, 1'b1);
    drain("mid_post_drain", 20);
    valid_i = '0;

    // Stalled channel 0 with channel 3 waiting.
    apply_reset("reset5");
    valid_i = 4'b1001;
    push_burst(0, 1, 1'b0);
    tick(vo);
    tick(vo);
    check_val("stall_first", 32'(q.size()), 32'd0);
    valid_i = 4'b1000;
`ifdef UNPACK_ARBITER_TIMEOUT_EN
    push_burst(3, BL, 1'b1);
    drain("timeout_drain", 40);
`else
    for (int i = 0; i < 20; i++) begin
      tick(vo);
      check_val("stall_valid", 32'(vo), 32'd0);
      check_val("stall_ready3", 32'(ready_o[3]), 32'd0);
      check_val("stall_chan", 32'(chan_o), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unpack_arbiter.md
Name: unpack_arbiter

Overview:
- Shares one downstream unpacker between num_req_p packed-word requesters.
- Round-robin grant; each grant is held for a burst of burst_len_p packed words, so one requester's pixel stream is never interleaved mid-burst.
- Sits between the per-camera/per-line packed sources and the unpacker's packed_i/valid_i/ready_o interface.
- Tags each forwarded word with its source channel.

Parameters:
- num_req_p, 4: number of requesters, must be ≥2.
- packed_width_p, 8: width of one packed word.
- burst_len_p, 16: words forwarded per grant, must be ≥1.
- timeout_p, 8: idle-cycle limit for the optional timeout feature, must be ≥1.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  synchronous active-low reset
- packed_i  in  num_req_p*packed_width_p  requester words; channel k occupies bits [k*packed_width_p +: packed_width_p]
- valid_i  in  num_req_p  per-requester valid
- ready_o  out  num_req_p  per-requester ready
- packed_o  out  packed_width_p  forwarded word
- valid_o  out  1  forwarded valid
- ready_i  in  1  downstream (unpacker) ready
- chan_o  out  $clog2(num_req_p)  channel id of the current grant
- last_o  out  1  high with the final word of a burst

Behaviour:
- Sampling and reset: all state is sampled on posedge clk_i. Reset takes effect when reset_ni==0 at the edge. Reset values:
  - state=IDLE, grant=0, rr_ptr=0, beat count=0.
  - valid_o=0, ready_o=0, last_o=0, chan_o=0, packed_o=0.
- FSM state IDLE:
  - valid_o=0, ready_o all 0.
  - If any valid_i is set, select the first set index scanning upward from rr_ptr with wrap. Register it as grant and go to BUSY next cycle.
  - This gives one arbitration bubble per burst, by design.
- FSM state BUSY, combinational pass-through with no added latency:
  - packed_o = packed_i[grant], valid_o = valid_i[grant].
  - ready_o[grant] = ready_i; every other ready_o bit = 0.
  - chan_o = grant.
  - fire = valid_o && ready_i.
- Beat counting:
  - The beat counter is a counter_roll instance with max burst_len_p-1, incremented on fire.
  - last_o = BUSY && (count == burst_len_p-1). last_o is meaningful only while valid_o is high.
- Burst end: on fire with last_o high:
  - count wraps to 0.
  - rr_ptr = grant+1, wrapping num_req_p-1 → 0.
  - state goes to IDLE.
- Grant stickiness: the grant is never revoked while BUSY, even if valid_i[grant] drops. The block waits indefinitely unless the optional feature is enabled.
- Outside BUSY: packed_o=0 and chan_o holds the last grant.
- Requester obligation: a requester must hold packed_i and valid_i stable until ready_o. The block does not check this.
- Simultaneous requests: in IDLE with several valid_i set, only the round-robin winner is granted. Losers see ready_o=0 and must keep valid_i asserted.
- burst_len_p==1: last_o is high on every BUSY word, and every word re-arbitrates.
- Reset mid-burst: returns to IDLE immediately with count=0 and rr_ptr=0. Partially forwarded bursts are not resumed; the downstream unpacker is reset by the same reset.
- Width rules:
  - count width = max(1, $clog2(burst_len_p)).
  - Grant and rr_ptr width = $clog2(num_req_p).
  - Pointer wrap is explicit compare-and-clear, not power-of-two truncation.

Optional Feature:
- Macro: UNPACK_ARBITER_TIMEOUT_EN.
- When defined:
  - A timeout counter increments each BUSY cycle with valid_i[grant]==0 and clears on any cycle where valid_i[grant]==1.
  - When the counter reaches timeout_p, the grant is released: state goes to IDLE, beat count clears, rr_ptr = grant+1.
  - No last_o is emitted, and no word is dropped.
- When undefined: no timeout logic exists and the grant is held until burst completion.

Decomposition:
- Package unpack_arbiter_pkg:
  - state enum (IDLE, BUSY).
  - function for round-robin first-set search given a request vector and start pointer.
- Beat counter reuses the existing counter_roll.
- No new sub-module.

Test Plan:
- Single requester: valid_i=4'b0100 continuously, ready_i=1, burst_len_p=4. Expected: one bubble cycle, then 4 words with chan_o=2 and last_o on the 4th, then bubble, then re-grant of channel 2.
- All requesting: valid_i=4'b1111, ready_i=1. Expected: grant order 0,1,2,3,0, each for exactly burst_len_p words, with no word forwarded for a non-granted channel.
- Backpressure: ready_i toggles 1,0,0,1 during BUSY. Expected: ready_o[grant] mirrors ready_i, the count advances only on fire, packed_o stays equal to packed_i[grant], and last_o only on the burst_len_p-th fire.
- Reset mid-burst: assert reset_ni=0 after 2 of 4 words. Expected next cycle: valid_o=0, ready_o=0, last_o=0, rr_ptr=0. After release with valid_i=4'b1010, channel 1 is granted.
- Stalled requester with UNPACK_ARBITER_TIMEOUT_EN and timeout_p=8: channel 0 sends 1 word, then drops valid while channel 3 is requesting. Expected: after 8 idle cycles, IDLE, then grant channel 3 with no last_o.
- Stalled requester without the macro: same stimulus. Expected: the grant stays on channel 0 indefinitely and channel 3's ready_o stays 0.
